// File: rtl/shift_seq_ctrl.sv
// Purpose: sequences an external N-bit universal shift register: load, cnt shifts, hold and return result.
// Latency: accept edge = cycle 0, LOAD in cycle 1, SHIFT in cycles 2..cnt+1, res_valid from cycle cnt+2.
// Backpressure: one command in flight; cmd_ready only in IDLE; res_ready low holds RESP (and the register) indefinitely.
// Optional feature: define SHIFT_SEQ_ABORT_EN to add an abort input that cancels an operation in LOAD or SHIFT.
module shift_seq_ctrl #(
    parameter int N  = 8,
    parameter int CW = $clog2(N+1)
) (
    input  logic          clk,
    input  logic          rst_n,
    // command side
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [N-1:0]  cmd_data,
    input  logic          cmd_dir,
    input  logic [CW-1:0] cmd_cnt,
    // shift register side
    output logic [1:0]    sr_sel,
    output logic [N-1:0]  sr_data,
    input  logic [N-1:0]  sr_q,
    // serial stream of bits leaving the register
    output logic          ser_bit,
    output logic          ser_valid,
    // result side
    output logic          res_valid,
    input  logic          res_ready,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic          abort,
`endif
    output logic [N-1:0]  res_data,
    output logic          busy
);

    // Shift register mode encodings
    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    // Largest meaningful shift count; anything above it clears the word anyway
    localparam logic [CW-1:0] CNT_MAX = CW'(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  data_q,  data_d;
    logic          dir_q,   dir_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [CW-1:0] rem_q,   rem_d;

    logic          cmd_fire;
    logic          res_fire;
    logic          abort_req;
    logic [CW-1:0] cnt_clamped;

    // Abort is only meaningful when the feature is built in
`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Handshake qualifiers and count clamp
    always_comb begin
        cmd_fire    = cmd_valid && (state_q == ST_IDLE);
        res_fire    = res_ready && (state_q == ST_RESP);
        cnt_clamped = (cmd_cnt > CNT_MAX) ? CNT_MAX : cmd_cnt;
    end

    // Next-state logic, command latching and the shift down-counter
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    // Capture everything now; later cmd_* changes are ignored
                    data_d  = cmd_data;
                    dir_d   = cmd_dir;
                    cnt_d   = cnt_clamped;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Counter is armed here so it holds cnt on the first SHIFT cycle
                rem_d = cnt_q;
                if (abort_req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_SHIFT: begin
                rem_d = rem_q - 1'b1;
                if (abort_req) begin
                    state_d = ST_IDLE;
                end else if (rem_q == CW'(1)) begin
                    // This edge performs the last shift
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        cmd_ready = 1'b0;
        sr_sel    = SEL_HOLD;
        sr_data   = '0;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        busy      = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_LOAD: begin
                sr_sel  = SEL_LOAD;
                sr_data = data_q;
            end
            ST_SHIFT: begin
                sr_sel    = dir_q ? SEL_LEFT : SEL_RIGHT;
                ser_valid = 1'b1;
                // Bit about to be discarded at the coming edge
                ser_bit   = dir_q ? sr_q[N-1] : sr_q[0];
            end
            ST_RESP: begin
                // Register is held, so sr_q is the stable final word
                res_valid = 1'b1;
                res_data  = sr_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // State and latched-command registers; reset never touches the shift register itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Purpose: randomized and directed bench for shift_seq_ctrl with a behavioural shift register.
// Latency: expectations are cycle-exact relative to the command accept edge.
// Backpressure: res_ready is held low for random stretches while a new command waits.
module tb_shift_seq_ctrl;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [N-1:0]  cmd_data;
    logic          cmd_dir;
    logic [CW-1:0] cmd_cnt;
    logic [1:0]    sr_sel;
    logic [N-1:0]  sr_data;
    logic [N-1:0]  sr_q = '0;
    logic          ser_bit;
    logic          ser_valid;
    logic          res_valid;
    logic          res_ready;
    logic [N-1:0]  res_data;
    logic          busy;
`ifdef SHIFT_SEQ_ABORT_EN
    logic          abort;
`endif

    int n_checks = 0;
    int n_errors = 0;

    shift_seq_ctrl #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_cnt   (cmd_cnt),
        .sr_sel    (sr_sel),
        .sr_data   (sr_data),
        .sr_q      (sr_q),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .res_valid (res_valid),
        .res_ready (res_ready),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural universal shift register, never reset by the controller
    always @(posedge clk) begin
        case (sr_sel)
            2'b01:   sr_q <= {1'b0, sr_q[N-1:1]};
            2'b10:   sr_q <= {sr_q[N-2:0], 1'b0};
            2'b11:   sr_q <= sr_data;
            default: sr_q <= sr_q;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; returns at a negedge with the controller idle
    task automatic wait_idle();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) chk("idle_timeout", 32'(cmd_ready), 32'd1);
    endtask

    // Reference: bit i leaving the register and the final word, from the rules alone
    function automatic logic exp_bit(input logic [N-1:0] d, input logic dr, input int i);
        return dr ? d[N-1-i] : d[i];
    endfunction

    function automatic logic [N-1:0] exp_result(input logic [N-1:0] d, input logic dr, input int c);
        if (c >= N) return '0;
        return dr ? (d << c) : (d >> c);
    endfunction

    // Full operation: accept, LOAD, SHIFT, RESP held 'hold' cycles, handshake
    task automatic run_cmd(input logic [N-1:0] d, input logic dr, input logic [CW-1:0] c_in, input int hold);
        int c;
        logic [N-1:0] r;
        logic [1:0] shsel;
        c     = (int'(c_in) > N) ? N : int'(c_in);
        r     = exp_result(d, dr, c);
        shsel = dr ? 2'b10 : 2'b01;
        wait_idle();
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_dir   = dr;
        cmd_cnt   = c_in;
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        // Keep presenting junk: it must neither be accepted nor alter the operation
        cmd_data = N'($urandom);
        cmd_dir  = 1'($urandom);
        cmd_cnt  = CW'($urandom);
        for (int k = 1; k <= c + 2; k++) begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'd1);
            chk("cmd_ready", 32'(cmd_ready), 32'd0);
            if (k == 1) begin
                chk("load_sel", 32'(sr_sel), 32'd3);
                chk("load_data", 32'(sr_data), 32'(d));
                chk("load_serv", 32'(ser_valid), 32'd0);
                chk("load_resv", 32'(res_valid), 32'd0);
            end else if (k <= c + 1) begin
                chk("shift_sel", 32'(sr_sel), 32'(shsel));
                chk("shift_serv", 32'(ser_valid), 32'd1);
                chk("shift_bit", 32'(ser_bit), 32'(exp_bit(d, dr, k - 2)));
                chk("shift_sdata", 32'(sr_data), 32'd0);
                chk("shift_resv", 32'(res_valid), 32'd0);
            end else begin
                chk("resp_valid", 32'(res_valid), 32'd1);
                chk("resp_data", 32'(res_data), 32'(r));
                chk("resp_sel", 32'(sr_sel), 32'd0);
                chk("resp_serv", 32'(ser_valid), 32'd0);
                chk("resp_bit", 32'(ser_bit), 32'd0);
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", 32'(res_data), 32'(r));
            chk("hold_sel", 32'(sr_sel), 32'd0);
            chk("hold_cmdrdy", 32'(cmd_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        // cmd_valid was high across the handshake edge; it must not have been taken
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_cmdrdy", 32'(cmd_ready), 32'd1);
        chk("post_sel", 32'(sr_sel), 32'd0);
        chk("post_resv", 32'(res_valid), 32'd0);
    endtask

    // Starts a cnt=5 right-shift op and returns at the negedge of the 2nd SHIFT cycle
    task automatic start_to_second_shift(input logic [N-1:0] d);
        wait_idle();
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_dir   = 1'b0;
        cmd_cnt   = CW'(5);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_data = N'($urandom);
        repeat (3) @(negedge clk);
        chk("mid_sel", 32'(sr_sel), 32'd1);
        chk("mid_sr", 32'(sr_q), 32'(d >> 1));
    endtask

    initial begin
        logic [N-1:0] d;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_dir   = 1'b0;
        cmd_cnt   = '0;
        res_ready = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        #1;
        chk("rst_sel", 32'(sr_sel), 32'd0);
        chk("rst_sdata", 32'(sr_data), 32'd0);
        chk("rst_serv", 32'(ser_valid), 32'd0);
        chk("rst_bit", 32'(ser_bit), 32'd0);
        chk("rst_resv", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmdrdy", 32'(cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_cmd(8'hA5, 1'b0, 4'd3, 0);
        run_cmd(8'h81, 1'b1, 4'd2, 0);
        run_cmd(8'h3C, 1'b0, 4'd0, 0);
        run_cmd(8'hFF, 1'b0, 4'd12, 0);
        run_cmd(8'h5A, 1'b1, 4'd8, 5);
        run_cmd(8'hC3, 1'b1, 4'd15, 1);

        // Randomized cases
        for (int i = 0; i < 40; i++) begin
            run_cmd(N'($urandom), 1'($urandom), CW'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        // Reset during the 2nd shift of a cnt=5 operation
        d = N'($urandom) | 8'h02;
        start_to_second_shift(d);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_sel", 32'(sr_sel), 32'd0);
        chk("mrst_resv", 32'(res_valid), 32'd0);
        chk("mrst_serv", 32'(ser_valid), 32'd0);
        repeat (2) @(negedge clk);
        chk("mrst_hold", 32'(sr_q), 32'(d >> 1));
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("mrst_nores", 32'(res_valid), 32'd0);
            chk("mrst_idle", 32'(busy), 32'd0);
        end
        chk("mrst_still", 32'(sr_q), 32'(d >> 1));

`ifdef SHIFT_SEQ_ABORT_EN
        // Abort at the same point; a command offered on the abort edge is not taken
        d = N'($urandom) | 8'h04;
        start_to_second_shift(d);
        abort     = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("abt_busy", 32'(busy), 32'd0);
        chk("abt_sel", 32'(sr_sel), 32'd0);
        chk("abt_resv", 32'(res_valid), 32'd0);
        chk("abt_cmdrdy", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        chk("abt_hold", 32'(sr_q), 32'(d >> 2));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abt_nores", 32'(res_valid), 32'd0);
        end
`endif

        // A normal op still works after the disruptions
        run_cmd(8'hA5, 1'b0, 4'd3, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
